// File: rtl/sram_resp_mem_pkg.sv
// Shared widths, constants and FSM state type for the SRAM responder.
// Pure declarations: no latency, no flow control.
package sram_resp_mem_pkg;

  localparam int unsigned SRAM_ADDR_W = 32;
  localparam int unsigned SRAM_DATA_W = 32;
  localparam int unsigned SRAM_WEN_W  = 4;

  localparam logic [SRAM_WEN_W-1:0]  SRAM_WEN_RD   = 4'b0000;
  localparam logic [SRAM_DATA_W-1:0] SRAM_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

endpackage

// File: rtl/sram_resp_mem_bank.sv
// DEPTH x 32 word array, byte-enabled write port and one registered read port.
// Read data appears the edge after rd_en and holds otherwise; no backpressure.
module sram_resp_mem_bank
  import sram_resp_mem_pkg::*;
#(
  parameter int unsigned             DEPTH    = 1024,
  parameter logic [SRAM_DATA_W-1:0]  ERR_DATA = SRAM_ERR_DATA,
  localparam int unsigned            AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SRAM_WEN_W-1:0]  wr_be,
  input  logic [AW-1:0]          wr_idx,
  input  logic [SRAM_DATA_W-1:0] wr_dat,
  input  logic                   rd_en,
  input  logic                   rd_hit,
  input  logic [AW-1:0]          rd_idx,
  output logic [SRAM_DATA_W-1:0] rdata
);

  logic [SRAM_DATA_W-1:0] mem [DEPTH];
  logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;

  // The array has no reset; the top-level clear pass initialises it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(SRAM_WEN_W); i++) begin
      if (wr_be[i]) begin
        mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = rd_hit ? mem[rd_idx] : ERR_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sram_resp_mem.sv
// Word-organised SRAM responder: self-clears after reset, then serves byte-masked requests.
// Read latency 1 cycle; busy during the clear, when requests are silently ignored.
module sram_resp_mem
  import sram_resp_mem_pkg::*;
#(
  parameter int unsigned             DEPTH     = 1024,
  parameter logic [SRAM_ADDR_W-1:0]  BASE_ADDR = 32'h0000_0000,
  parameter logic [SRAM_DATA_W-1:0]  ERR_DATA  = SRAM_ERR_DATA
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [SRAM_WEN_W-1:0]  wen,
  input  logic [SRAM_ADDR_W-1:0] addr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  output logic [SRAM_DATA_W-1:0] rdata,
  output logic                   busy,
  output logic [7:0]             err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e                 state_q, state_d;
  logic [AW-1:0]          clr_idx_q, clr_idx_d;
  logic [7:0]             err_cnt_q, err_cnt_d;

  logic [SRAM_ADDR_W-1:0] off;
  logic                   in_range;
  logic [AW-1:0]          req_idx;
  logic                   req_vld, req_rd, req_wr;

  logic [SRAM_WEN_W-1:0]  wr_be;
  logic [AW-1:0]          wr_idx;
  logic [SRAM_DATA_W-1:0] wr_dat;

  // Offset wraps, so addresses below BASE_ADDR land far out of range.
  always_comb begin
    off      = addr - BASE_ADDR;
    in_range = (off >> (AW + 2)) == '0;
    req_idx  = off[AW+1:2];
    req_vld  = (state_q == ST_READY) && en;
    req_rd   = req_vld && (wen == SRAM_WEN_RD);
    req_wr   = req_vld && (wen != SRAM_WEN_RD);
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    err_cnt_d = err_cnt_q;
    wr_be     = '0;
    wr_idx    = req_idx;
    wr_dat    = wdata;
    case (state_q)
      ST_CLEAR: begin
        wr_be     = '1;
        wr_idx    = clr_idx_q;
        wr_dat    = '0;
        clr_idx_d = clr_idx_q + AW'(1);
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (req_wr && in_range) begin
          wr_be = wen;
        end
        if (req_vld && !in_range && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  sram_resp_mem_bank #(
    .DEPTH    (DEPTH),
    .ERR_DATA (ERR_DATA)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_be  (wr_be),
    .wr_idx (wr_idx),
    .wr_dat (wr_dat),
    .rd_en  (req_rd),
    .rd_hit (in_range),
    .rd_idx (req_idx),
    .rdata  (rdata)
  );

  assign busy    = (state_q == ST_CLEAR);
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sram_resp_mem.sv
// Bench for sram_resp_mem: directed requests push expectations into a scoreboard,
// a negedge monitor pops and compares them when they fall due.
module tb_sram_resp_mem;

  localparam int K_RD   = 0;
  localparam int K_BUSY = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];

  sram_resp_mem #(
    .DEPTH     (1024),
    .BASE_ADDR (32'h0000_0000),
    .ERR_DATA  (32'hDEAD_BEEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .wen     (wen),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drv(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en    = 1'b1;
    wen   = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic idle();
    en  = 1'b0;
    wen = 4'h0;
  endtask

  // Expectation becomes due 'dly' rising edges after the current negedge.
  task automatic expect_q(input int kind, input int dly, input logic [31:0] v, input string name);
    exp_t e;
    e.due  = cyc + dly;
    e.kind = kind;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      case (e.kind)
        K_RD:    act = rdata;
        K_BUSY:  act = {31'b0, busy};
        default: act = {24'b0, err_cnt};
      endcase
      n_tests++;
      if (e.due != cyc || act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got %h, expected %h (cycle %0d, due %0d)",
                 e.name, act, e.val, cyc, e.due);
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    rst = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    repeat (3) step();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h1);
    chk("rst_err", {24'b0, err_cnt}, 32'h0);

    // First clear pass; a write to word 0 is attempted on the second clear cycle.
    rst = 1'b1;
    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      if (cnt == 2) drv(4'hF, 32'h0, 32'hFFFF_FFFF);
      else          idle();
      step();
    end
    chk("clear_len", cnt, 32'd1024);

    drv(4'h0, 32'h10, '0);
    expect_q(K_RD, 1, 32'h0, "rd_at_busy_fall");
    expect_q(K_ERR, 1, 32'h0, "err_after_clear");
    step();
    drv(4'h0, 32'h0, '0);
    expect_q(K_RD, 1, 32'h0, "clear_wr_ignored");
    step();

    // Byte-masked merge, read back on the very next cycle.
    drv(4'hF, 32'h40, 32'h1122_3344);  step();
    drv(4'h3, 32'h40, 32'hAABB_CCDD);  step();
    drv(4'h0, 32'h40, '0); expect_q(K_RD, 1, 32'h1122_CCDD, "merge_rd_40"); step();
    drv(4'h0, 32'h43, '0); expect_q(K_RD, 1, 32'h1122_CCDD, "merge_rd_43"); step();
    drv(4'hF, 32'h44, 32'h0102_0304);  step();
    drv(4'hC, 32'h44, 32'hA0B0_C0D0);  step();
    drv(4'h0, 32'h44, '0); expect_q(K_RD, 1, 32'hA0B0_0304, "merge_hi_44"); step();

    // Latency and hold across idle cycles and a write.
    drv(4'hF, 32'h8, 32'h5);  step();
    drv(4'h0, 32'h8, '0); expect_q(K_RD, 1, 32'h5, "lat_rd_8"); step();
    idle();               expect_q(K_RD, 1, 32'h5, "hold_idle1"); step();
    idle();               expect_q(K_RD, 1, 32'h5, "hold_idle2"); step();
    drv(4'hF, 32'hC, 32'h99); expect_q(K_RD, 1, 32'h5, "hold_on_write"); step();
    drv(4'h0, 32'hC, '0); expect_q(K_RD, 1, 32'h99, "rd_c"); step();

    // Out-of-range reads and writes, last valid word, saturation.
    drv(4'h0, 32'h1000, '0);
    expect_q(K_RD, 1, 32'hDEAD_BEEF, "oor_rd");
    expect_q(K_ERR, 1, 32'd1, "oor_rd_err");
    step();
    drv(4'hF, 32'h1000, 32'h1234_5678);
    expect_q(K_ERR, 1, 32'd2, "oor_wr_err");
    expect_q(K_RD, 1, 32'hDEAD_BEEF, "oor_wr_hold");
    step();
    drv(4'h0, 32'h0, '0); expect_q(K_RD, 1, 32'h0, "oor_wr_dropped"); step();
    drv(4'hF, 32'hFFC, 32'hCAFE_F00D); step();
    drv(4'h0, 32'hFFC, '0);
    expect_q(K_RD, 1, 32'hCAFE_F00D, "last_word");
    expect_q(K_ERR, 1, 32'd2, "last_word_no_err");
    step();
    drv(4'h0, 32'hFFFF_FFFC, '0);
    expect_q(K_RD, 1, 32'hDEAD_BEEF, "oor_high");
    expect_q(K_ERR, 1, 32'd3, "oor_high_err");
    step();
    for (int i = 0; i < 300; i++) begin
      drv((i % 2 == 1) ? 4'hF : 4'h0, 32'h2000 + 32'(i) * 4, 32'(i));
      step();
    end
    idle();
    expect_q(K_ERR, 1, 32'hFF, "err_sat");
    expect_q(K_RD, 1, 32'hDEAD_BEEF, "oor_loop_rd");
    step();

    // Reset in the middle of a read request.
    drv(4'h0, 32'h44, '0);
    #2 rst = 1'b0;
    #1;
    chk("midreq_rdata", rdata, 32'h0);
    chk("midreq_busy", {31'b0, busy}, 32'h1);
    chk("midreq_err", {24'b0, err_cnt}, 32'h0);
    idle();
    repeat (3) step();

    // Reset again at clear index 500; the next clear must take the full length.
    rst = 1'b1;
    repeat (500) step();
    rst = 1'b0;
    #1;
    chk("midclr_busy", {31'b0, busy}, 32'h1);
    chk("midclr_rdata", rdata, 32'h0);
    repeat (2) step();
    rst = 1'b1;
    cnt = 0;
    while (busy && cnt < 5000) begin
      cnt++;
      step();
    end
    chk("clear_len_again", cnt, 32'd1024);
    drv(4'h0, 32'h44, '0);
    expect_q(K_RD, 1, 32'h0, "recleared_44");
    expect_q(K_BUSY, 1, 32'h0, "ready_after_reclear");
    step();
    drv(4'h0, 32'hFFC, '0); expect_q(K_RD, 1, 32'h0, "recleared_ffc"); step();
    idle();
    repeat (3) step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
